// File: rtl/control_unit_hs.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller with a memory
// ready handshake, a wait-timeout fault and a single-level vectored interrupt.
module control_unit_hs #(
    parameter int IW          = 8,
    parameter int MEM_WAIT_EN = 1,
    parameter int MAX_WAIT    = 15,
    parameter int IRQ_EN      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instruction,
    input  logic          zero_flag,
    input  logic          mem_ready,
    input  logic          irq,
    output logic          pc_enable,
    output logic          pc_load,
    output logic          reg_write,
    output logic          mem_write,
    output logic          mem_to_reg,
    output logic          use_imm,
    output logic          ir_load,
    output logic          imm_load,
    output logic          alu_latch,
    output logic          halt,
    output logic          mdr_load,
    output logic          mem_req,
    output logic          pc_save,
    output logic          pc_vector,
    output logic          pc_restore,
    output logic          irq_ack,
    output logic          int_enabled,
    output logic          bus_error,
    output logic [3:0]    alu_op,
    output logic [3:0]    state_o
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXECUTE   = 4'd2;
    localparam logic [3:0] S_MEMORY    = 4'd3;
    localparam logic [3:0] S_WRITEBACK = 4'd4;
    localparam logic [3:0] S_HALT      = 4'd5;
    localparam logic [3:0] S_FETCH_IMM = 4'd6;
    localparam logic [3:0] S_IRQ       = 4'd7;
    localparam logic [3:0] S_FAULT     = 4'd8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_ST  = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hE;

    localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

    logic [3:0] state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       ie_q, ie_d;
    logic [7:0] wcnt_q, wcnt_d;

    logic [3:0] opcode, sub;
    logic       rdy, irq_take, wait_to, mem_state;

    assign opcode    = instruction[IW-1 -: 4];
    assign sub       = instruction[3:0];
    assign rdy       = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    // Interrupt decision always uses the ie value held before this cycle's update.
    assign irq_take  = (IRQ_EN != 0) && ie_q && irq;
    assign wait_to   = !rdy && (wcnt_q == MAX_W);
    assign mem_state = (state_q == S_FETCH) || (state_q == S_FETCH_IMM) ||
                       (state_q == S_MEMORY);

    generate
        if (IW > 8) begin : g_unused
            logic unused_instr;
            assign unused_instr = ^instruction[IW-5:4];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        ie_d       = ie_q;
        pc_enable  = 1'b0;
        pc_load    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        use_imm    = 1'b0;
        ir_load    = 1'b0;
        imm_load   = 1'b0;
        alu_latch  = 1'b0;
        halt       = 1'b0;
        mdr_load   = 1'b0;
        mem_req    = 1'b0;
        pc_save    = 1'b0;
        pc_vector  = 1'b0;
        pc_restore = 1'b0;
        irq_ack    = 1'b0;
        bus_error  = 1'b0;
        alu_op     = 4'h0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (rdy) begin
                    ir_load   = 1'b1;
                    pc_enable = 1'b1;
                    state_d   = S_DECODE;
                end else if (wait_to) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_op   = opcode;
                opcode_d = opcode;
                case (opcode)
                    OP_HLT:                state_d = S_HALT;
                    OP_LDI, OP_JMP, OP_JZ: state_d = S_FETCH_IMM;
                    default:               state_d = S_EXECUTE;
                endcase
            end
            S_FETCH_IMM: begin
                mem_req = 1'b1;
                if (rdy) begin
                    imm_load  = 1'b1;
                    pc_enable = 1'b1;
                    state_d   = S_EXECUTE;
                end else if (wait_to) begin
                    state_d = S_FAULT;
                end
            end
            S_EXECUTE: begin
                alu_op    = opcode_q;
                alu_latch = 1'b1;
                if ((opcode_q == OP_JMP) || ((opcode_q == OP_JZ) && zero_flag)) begin
                    pc_load   = 1'b1;
                    pc_enable = 1'b1;
                end
                if ((opcode_q == OP_LD) || (opcode_q == OP_ST))
                    state_d = S_MEMORY;
                else
                    state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                mem_req   = 1'b1;
                mem_write = (opcode_q == OP_ST);
                if (rdy) begin
                    mdr_load = (opcode_q == OP_LD);
                    state_d  = S_WRITEBACK;
                end else if (wait_to) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                case (opcode_q)
                    OP_LD: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 1'b1;
                    end
                    OP_LDI: begin
                        reg_write = 1'b1;
                        use_imm   = 1'b1;
                    end
                    OP_NOP: begin
                        case (sub)
                            4'h1: ie_d = 1'b1;
                            4'h2: ie_d = 1'b0;
                            4'hF: begin
                                pc_restore = 1'b1;
                                ie_d       = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_ST, OP_JMP, OP_JZ, OP_HLT: ;
                    default: reg_write = 1'b1;
                endcase
                state_d = irq_take ? S_IRQ : S_FETCH;
            end
            S_HALT: begin
                halt = 1'b1;
                if (irq_take) state_d = S_IRQ;
            end
            S_IRQ: begin
                irq_ack   = 1'b1;
                pc_save   = 1'b1;
                pc_vector = 1'b1;
                ie_d      = 1'b0;
                state_d   = S_FETCH;
            end
            S_FAULT: begin
                bus_error = 1'b1;
                halt      = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Counter restarts on every state entry and on every completed access.
    assign wcnt_d = (mem_state && !rdy && (state_d == state_q)) ? wcnt_q + 8'd1 : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            opcode_q <= 4'h0;
            ie_q     <= 1'b0;
            wcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ie_q     <= ie_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign int_enabled = ie_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_control_unit_hs.sv
// Scoreboard bench for control_unit_hs: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares. DUT 1 runs with MEM_WAIT_EN=0.
module tb_control_unit_hs;

    localparam logic [3:0] ST_F = 4'd0, ST_D = 4'd1, ST_E = 4'd2, ST_M = 4'd3,
                           ST_W = 4'd4, ST_H = 4'd5, ST_FI = 4'd6, ST_IQ = 4'd7,
                           ST_FT = 4'd8;

    localparam logic [17:0] PCE  = 18'h00001, PCL  = 18'h00002, RW   = 18'h00004,
                            MW   = 18'h00008, M2R  = 18'h00010, UIM  = 18'h00020,
                            IRL  = 18'h00040, IML  = 18'h00080, ALAT = 18'h00100,
                            HLTS = 18'h00200, MDR  = 18'h00400, MREQ = 18'h00800,
                            PSAV = 18'h01000, PVEC = 18'h02000, PRST = 18'h04000,
                            IACK = 18'h08000, IE   = 18'h10000, BERR = 18'h20000;
    localparam logic [17:0] FOK = MREQ | IRL | PCE;

    localparam logic [7:0] I_NOP = 8'h00, I_EI = 8'h01, I_DI = 8'h02, I_IRET = 8'h0F,
                           I_ADD = 8'h10, I_LDI = 8'h90, I_LD = 8'hA0, I_ST = 8'hB0,
                           I_JZ = 8'hD0, I_HLT = 8'hE0;

    typedef struct {
        logic [3:0]  st;
        logic [3:0]  alu;
        logic [17:0] s;
        string       nm;
    } exp_t;

    logic       clk;
    logic [1:0] rst_v, rdy_v, irq_v, z_v;
    logic [7:0] ins_v [2];

    logic [17:0] obs  [2];
    logic [3:0]  alu_o[2];
    logic [3:0]  st_o [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pc_enable, pc_load, reg_write, mem_write, mem_to_reg, use_imm, ir_load,
              imm_load, alu_latch, halt, mdr_load, mem_req, pc_save, pc_vector,
              pc_restore, irq_ack, int_enabled, bus_error;
        control_unit_hs #(
            .IW(8), .MEM_WAIT_EN(g == 0 ? 1 : 0), .MAX_WAIT(15), .IRQ_EN(1)
        ) u_dut (
            .clk(clk), .reset(rst_v[g]), .instruction(ins_v[g]), .zero_flag(z_v[g]),
            .mem_ready(rdy_v[g]), .irq(irq_v[g]),
            .pc_enable(pc_enable), .pc_load(pc_load), .reg_write(reg_write),
            .mem_write(mem_write), .mem_to_reg(mem_to_reg), .use_imm(use_imm),
            .ir_load(ir_load), .imm_load(imm_load), .alu_latch(alu_latch), .halt(halt),
            .mdr_load(mdr_load), .mem_req(mem_req), .pc_save(pc_save),
            .pc_vector(pc_vector), .pc_restore(pc_restore), .irq_ack(irq_ack),
            .int_enabled(int_enabled), .bus_error(bus_error),
            .alu_op(alu_o[g]), .state_o(st_o[g])
        );
        assign obs[g] = {bus_error, int_enabled, irq_ack, pc_restore, pc_vector, pc_save,
                         mem_req, mdr_load, halt, alu_latch, imm_load, ir_load, use_imm,
                         mem_to_reg, mem_write, reg_write, pc_load, pc_enable};
    end

    task automatic chk(input int sel, input exp_t e);
        n_cmp++;
        if (st_o[sel] !== e.st || alu_o[sel] !== e.alu || obs[sel] !== e.s) begin
            n_bad++;
            $display("FAIL dut%0d %s: got state=%0d alu=%h strb=%h, want state=%0d alu=%h strb=%h",
                     sel, e.nm, st_o[sel], alu_o[sel], obs[sel], e.st, e.alu, e.s);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) chk(0, q0.pop_front());
        if (q1.size() > 0) chk(1, q1.pop_front());
    end

    task automatic step(input int sel, input string nm, input logic rst, input logic rdy,
                        input logic iq, input logic z, input logic [7:0] ins,
                        input logic [3:0] st, input logic [3:0] alu, input logic [17:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_v[sel] = rst;
        rdy_v[sel] = rdy;
        irq_v[sel] = iq;
        z_v[sel]   = z;
        ins_v[sel] = ins;
        e.st = st; e.alu = alu; e.s = s; e.nm = nm;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic s0(input string nm, input logic rdy, input logic iq, input logic [7:0] ins,
                      input logic [3:0] st, input logic [3:0] alu, input logic [17:0] s);
        step(0, nm, 1'b0, rdy, iq, 1'b0, ins, st, alu, s);
    endtask

    task automatic s1(input string nm, input logic z, input logic [7:0] ins,
                      input logic [3:0] st, input logic [3:0] alu, input logic [17:0] s);
        step(1, nm, 1'b0, 1'b0, 1'b0, z, ins, st, alu, s);
    endtask

    initial begin
        rst_v = 2'b11; rdy_v = 2'b00; irq_v = 2'b00; z_v = 2'b00;
        ins_v[0] = I_ADD; ins_v[1] = I_JZ;

        // reset state, then ADD with zero waits
        step(0, "rst_idle", 1'b1, 1'b0, 1'b0, 1'b0, I_ADD, ST_F, 4'h0, MREQ);
        step(0, "rst_rdy",  1'b0, 1'b1, 1'b0, 1'b0, I_ADD, ST_F, 4'h0, FOK);
        s0("add_dec", 1, 0, I_ADD, ST_D, 4'h1, 18'h0);
        s0("add_ex",  1, 0, I_ADD, ST_E, 4'h1, ALAT);
        s0("add_wb",  1, 0, I_ADD, ST_W, 4'h0, RW);

        // LD with three wait states in MEMORY
        s0("ld_f",   1, 0, I_LD, ST_F, 4'h0, FOK);
        s0("ld_dec", 1, 0, I_LD, ST_D, 4'hA, 18'h0);
        s0("ld_ex",  1, 0, I_LD, ST_E, 4'hA, ALAT);
        for (int i = 0; i < 3; i++) s0("ld_wait", 0, 0, I_LD, ST_M, 4'h0, MREQ);
        s0("ld_mem", 1, 0, I_LD, ST_M, 4'h0, MREQ | MDR);
        s0("ld_wb",  1, 0, I_LD, ST_W, 4'h0, RW | M2R);

        // ST holds mem_write across its wait state
        s0("st_f",    1, 0, I_ST, ST_F, 4'h0, FOK);
        s0("st_dec",  1, 0, I_ST, ST_D, 4'hB, 18'h0);
        s0("st_ex",   1, 0, I_ST, ST_E, 4'hB, ALAT);
        s0("st_wait", 0, 0, I_ST, ST_M, 4'h0, MREQ | MW);
        s0("st_mem",  1, 0, I_ST, ST_M, 4'h0, MREQ | MW);
        s0("st_wb",   1, 0, I_ST, ST_W, 4'h0, 18'h0);

        // LDI through FETCH_IMM with one wait
        s0("ldi_f",    1, 0, I_LDI, ST_F,  4'h0, FOK);
        s0("ldi_dec",  1, 0, I_LDI, ST_D,  4'h9, 18'h0);
        s0("ldi_wait", 0, 0, I_LDI, ST_FI, 4'h0, MREQ);
        s0("ldi_imm",  1, 0, I_LDI, ST_FI, 4'h0, MREQ | IML | PCE);
        s0("ldi_ex",   1, 0, I_LDI, ST_E,  4'h9, ALAT);
        s0("ldi_wb",   1, 0, I_LDI, ST_W,  4'h0, RW | UIM);

        // exactly MAX_WAIT not-ready cycles is tolerated
        for (int i = 0; i < 15; i++) s0("nop_wait", 0, 0, I_NOP, ST_F, 4'h0, MREQ);
        s0("nop_f",   1, 0, I_NOP, ST_F, 4'h0, FOK);
        s0("nop_dec", 1, 0, I_NOP, ST_D, 4'h0, 18'h0);
        s0("nop_ex",  1, 0, I_NOP, ST_E, 4'h0, ALAT);
        s0("nop_wb",  1, 0, I_NOP, ST_W, 4'h0, 18'h0);

        // EI with irq already high: old ie=0, so no interrupt here
        s0("ei_f",   1, 0, I_EI, ST_F, 4'h0, FOK);
        s0("ei_dec", 1, 0, I_EI, ST_D, 4'h0, 18'h0);
        s0("ei_ex",  1, 0, I_EI, ST_E, 4'h0, ALAT);
        s0("ei_wb",  1, 1, I_EI, ST_W, 4'h0, 18'h0);
        s0("a2_f",   1, 1, I_ADD, ST_F,  4'h0, FOK | IE);
        s0("a2_dec", 1, 1, I_ADD, ST_D,  4'h1, IE);
        s0("a2_ex",  1, 1, I_ADD, ST_E,  4'h1, ALAT | IE);
        s0("a2_wb",  1, 1, I_ADD, ST_W,  4'h0, RW | IE);
        s0("a2_irq", 1, 1, I_ADD, ST_IQ, 4'h0, IACK | PSAV | PVEC | IE);

        // re-enable, then HLT woken by irq
        s0("e2_f",   1, 0, I_EI, ST_F, 4'h0, FOK);
        s0("e2_dec", 1, 0, I_EI, ST_D, 4'h0, 18'h0);
        s0("e2_ex",  1, 0, I_EI, ST_E, 4'h0, ALAT);
        s0("e2_wb",  1, 0, I_EI, ST_W, 4'h0, 18'h0);
        s0("h_f",    1, 0, I_HLT, ST_F, 4'h0, FOK | IE);
        s0("h_dec",  1, 0, I_HLT, ST_D, 4'hE, IE);
        for (int i = 0; i < 4; i++) s0("h_halt", 1, 0, I_HLT, ST_H, 4'h0, HLTS | IE);
        s0("h_irqhi", 1, 1, I_HLT, ST_H,  4'h0, HLTS | IE);
        s0("h_irq",   1, 0, I_HLT, ST_IQ, 4'h0, IACK | PSAV | PVEC | IE);

        // IRET with irq in its writeback: old ie=0, not taken
        s0("i_f",   1, 0, I_IRET, ST_F, 4'h0, FOK);
        s0("i_dec", 1, 0, I_IRET, ST_D, 4'h0, 18'h0);
        s0("i_ex",  1, 0, I_IRET, ST_E, 4'h0, ALAT);
        s0("i_wb",  1, 1, I_IRET, ST_W, 4'h0, PRST);
        s0("d_f",   1, 0, I_DI, ST_F, 4'h0, FOK | IE);
        s0("d_dec", 1, 0, I_DI, ST_D, 4'h0, IE);
        s0("d_ex",  1, 0, I_DI, ST_E, 4'h0, ALAT | IE);
        s0("d_wb",  1, 0, I_DI, ST_W, 4'h0, IE);

        // MAX_WAIT+1 not-ready cycles in FETCH -> sticky FAULT, cleared by reset
        for (int i = 0; i < 16; i++) s0("flt_wait", 0, 0, I_NOP, ST_F, 4'h0, MREQ);
        s0("flt",        0, 0, I_NOP, ST_FT, 4'h0, BERR | HLTS);
        s0("flt_sticky", 1, 0, I_NOP, ST_FT, 4'h0, BERR | HLTS);
        step(0, "flt_rst", 1'b1, 1'b1, 1'b0, 1'b0, I_NOP, ST_FT, 4'h0, BERR | HLTS);
        s0("post_rst", 1, 0, I_NOP, ST_F, 4'h0, FOK);

        // MEM_WAIT_EN=0 instance: mem_ready=0 never stalls; JZ taken only on zero
        step(1, "nw_rst", 1'b1, 1'b0, 1'b0, 1'b0, I_JZ, ST_F, 4'h0, FOK);
        s1("jz0_f",   0, I_JZ, ST_F,  4'h0, FOK);
        s1("jz0_dec", 0, I_JZ, ST_D,  4'hD, 18'h0);
        s1("jz0_imm", 0, I_JZ, ST_FI, 4'h0, MREQ | IML | PCE);
        s1("jz0_ex",  0, I_JZ, ST_E,  4'hD, ALAT);
        s1("jz0_wb",  0, I_JZ, ST_W,  4'h0, 18'h0);
        s1("jz1_f",   1, I_JZ, ST_F,  4'h0, FOK);
        s1("jz1_dec", 1, I_JZ, ST_D,  4'hD, 18'h0);
        s1("jz1_imm", 1, I_JZ, ST_FI, 4'h0, MREQ | IML | PCE);
        s1("jz1_ex",  1, I_JZ, ST_E,  4'hD, ALAT | PCL | PCE);
        s1("jz1_wb",  1, I_JZ, ST_W,  4'h0, 18'h0);
        s1("nw_f",    0, I_NOP, ST_F, 4'h0, FOK);

        @(posedge clk);
        @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, want 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
